rf_write_arbiter: RTL and testbench

Shares the single write port of the 8×16 general-purpose register file between two writeback requesters. Requester A is the execute/ALU writeback and requester B is the memory/load writeback. Each requester has a one-entry holding buffer with a valid/ready handshake. Held writes drain oldest-first into a registered write port (`we`/`ws`/`wd`) that connects directly to the register file. A pending-write mask tells decode which registers still have an uncommitted write in flight, so decode can stall on a read-after-write hazard.

---
 rtl/rf_write_arbiter_if.sv | 31 +++
 rtl/rf_write_arbiter.sv | 97 +++++++++
 tb/tb_rf_write_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Register-file write arbiter bundle: two writeback requesters in, one
// registered register-file write port and decode hazard status out.
interface rf_write_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NREG   = 8
);
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              we;
   logic [ADDR_W-1:0] ws;
   logic [DATA_W-1:0] wd;
   logic [NREG-1:0]   pend_mask;
   logic              idle;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, we, ws, wd, pend_mask, idle
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, we, ws, wd, pend_mask, idle
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Oldest-first arbiter between ALU (A) and load (B) writeback, each with a
// one-entry holding buffer, feeding a registered register-file write port.
module rf_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NREG   = 8
) (
   input  logic               clk,
   input  logic               reset,
   rf_write_arbiter_if.slave  bus
);
   logic              ha_v_q, ha_v_d, hb_v_q, hb_v_d;
   logic [ADDR_W-1:0] ha_addr_q, hb_addr_q;
   logic [DATA_W-1:0] ha_data_q, hb_data_q;
   logic              a_old_q, a_old_d;
   logic              we_q;
   logic [ADDR_W-1:0] ws_q;
   logic [DATA_W-1:0] wd_q;
   logic              sel_a, sel_b, acc_a, acc_b, a_keep, b_keep;
   logic [NREG-1:0]   pend;

   always_comb begin
      sel_a  = ha_v_q && (!hb_v_q || a_old_q);
      sel_b  = hb_v_q && (!ha_v_q || !a_old_q);
      acc_a  = bus.a_valid && (!ha_v_q || sel_a);
      acc_b  = bus.b_valid && (!hb_v_q || sel_b);
      a_keep = ha_v_q && !sel_a;
      b_keep = hb_v_q && !sel_b;
      ha_v_d = acc_a || a_keep;
      hb_v_d = acc_b || b_keep;
      // A buffer that stays held is always older than anything loaded now;
      // a simultaneous load of both puts A first.
      a_old_d = a_old_q;
      if (acc_a && acc_b)
         a_old_d = 1'b1;
      else if (acc_a)
         a_old_d = !b_keep;
      else if (acc_b)
         a_old_d = a_keep;
      else if (sel_a && b_keep)
         a_old_d = 1'b0;
      else if (sel_b && a_keep)
         a_old_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ha_v_q    <= 1'b0;
         hb_v_q    <= 1'b0;
         ha_addr_q <= '0;
         hb_addr_q <= '0;
         ha_data_q <= '0;
         hb_data_q <= '0;
         a_old_q   <= 1'b1;
         we_q      <= 1'b0;
         ws_q      <= '0;
         wd_q      <= '0;
      end else begin
         ha_v_q  <= ha_v_d;
         hb_v_q  <= hb_v_d;
         a_old_q <= a_old_d;
         we_q    <= ha_v_q || hb_v_q;
         if (acc_a) begin
            ha_addr_q <= bus.a_addr;
            ha_data_q <= bus.a_data;
         end
         if (acc_b) begin
            hb_addr_q <= bus.b_addr;
            hb_data_q <= bus.b_data;
         end
         if (sel_a) begin
            ws_q <= ha_addr_q;
            wd_q <= ha_data_q;
         end else if (sel_b) begin
            ws_q <= hb_addr_q;
            wd_q <= hb_data_q;
         end
      end
   end

   always_comb begin
      pend = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         pend[r] = (ha_v_q && ha_addr_q == ADDR_W'(r)) ||
                   (hb_v_q && hb_addr_q == ADDR_W'(r)) ||
                   (we_q   && ws_q      == ADDR_W'(r));
      end
   end

   assign bus.a_ready   = !ha_v_q || sel_a;
   assign bus.b_ready   = !hb_v_q || sel_b;
   assign bus.we        = we_q;
   assign bus.ws        = ws_q;
   assign bus.wd        = wd_q;
   assign bus.pend_mask = pend;
   assign bus.idle      = !ha_v_q && !hb_v_q && !we_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: per-cycle vector table plus reset,
// saturation and back-pressure sequences checked against a reference queue.
module tb_rf_write_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(3), .NREG(8)) bus ();

   rf_write_arbiter #(.DATA_W(16), .ADDR_W(3), .NREG(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        av;
      logic [2:0]  aa;
      logic [15:0] ad;
      logic        bv;
      logic [2:0]  ba;
      logic [15:0] bd;
      logic        ar;
      logic        br;
      logic        we;
      logic [2:0]  ws;
      logic [15:0] wd;
      logic [7:0]  pm;
      logic        idle;
   } vec_t;

   vec_t        tv[16];
   logic [18:0] wlog[$];
   int          wcyc[$];
   logic [18:0] expq[$];
   logic [15:0] rf[8];
   int          r3_writes = 0;
   logic        ardy[64];
   logic        brdy[64];

   // Each negedge with we=1 is exactly one write committing at the next edge.
   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         wlog.push_back({bus.ws, bus.wd});
         wcyc.push_back(cyc);
         rf[bus.ws] = bus.wd;
         if (bus.ws == 3'd3) r3_writes++;
      end
      cyc++;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic idle_inputs();
      bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
   endtask

   task automatic stream(input int ncyc, input int na, input int nb, output int nacc);
      int ka, kb;
      ka = 0; kb = 0; nacc = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         bus.a_valid = (c < na);
         bus.a_addr  = 3'(ka);
         bus.a_data  = 16'hA000 | 16'(ka);
         bus.b_valid = (c < nb);
         bus.b_addr  = 3'(kb + 3);
         bus.b_data  = 16'hB000 | 16'(kb);
         #1;
         ardy[c] = bus.a_ready;
         brdy[c] = bus.b_ready;
         if (bus.a_valid && bus.a_ready) begin
            expq.push_back({bus.a_addr, bus.a_data});
            ka++; nacc++;
         end
         if (bus.b_valid && bus.b_ready) begin
            expq.push_back({bus.b_addr, bus.b_data});
            kb++; nacc++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic drain_check(input string tag, input int start, input int nacc, input bit alt);
      int n, nw;
      logic [18:0] e;
      n = 0;
      while (bus.idle !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " drain"}, 32'(n < 100), 32'd1);
      @(negedge clk);
      nw = wlog.size() - start;
      chk({tag, " writes"}, nw, nacc);
      for (int i = 0; i < nw; i++) begin
         e = (expq.size() > 0) ? expq.pop_front() : 19'h7ffff;
         chk($sformatf("%s order[%0d]", tag, i), 32'(wlog[start + i]), 32'(e));
         if (alt && i > 0)
            chk($sformatf("%s alternate[%0d]", tag, i),
                32'(wlog[start + i][15:12] != wlog[start + i - 1][15:12]), 32'd1);
      end
      if (nw > 0)
         chk({tag, " back-to-back"}, wcyc[start + nw - 1] - wcyc[start] + 1, nw);
      expq.delete();
   endtask

   initial begin
      int nacc, start, r3_before;

      //        av    aa    ad        bv    ba    bd        ar    br    we    ws    wd        pm     idle
      tv[0]  = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 8'h20, 1'b0};
      tv[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd5, 16'h1234, 8'h20, 1'b0};
      tv[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd5, 16'h1234, 8'h00, 1'b1};
      tv[3]  = '{1'b1, 3'd2, 16'h0001, 1'b1, 3'd2, 16'h0002, 1'b1, 1'b0, 1'b0, 3'd5, 16'h1234, 8'h04, 1'b0};
      tv[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd2, 16'h0001, 8'h04, 1'b0};
      tv[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd2, 16'h0002, 8'h04, 1'b0};
      tv[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0002, 8'h00, 1'b1};
      tv[7]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'hBBBB, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0002, 8'h02, 1'b0};
      tv[8]  = '{1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd1, 16'hBBBB, 8'h02, 1'b0};
      tv[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd1, 16'hAAAA, 8'h02, 1'b0};
      tv[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd1, 16'hAAAA, 8'h00, 1'b1};
      tv[11] = '{1'b1, 3'd3, 16'h0333, 1'b1, 3'd4, 16'h0444, 1'b1, 1'b0, 1'b0, 3'd1, 16'hAAAA, 8'h18, 1'b0};
      tv[12] = '{1'b1, 3'd4, 16'h0555, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd3, 16'h0333, 8'h18, 1'b0};
      tv[13] = '{1'b1, 3'd4, 16'h0555, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd4, 16'h0444, 8'h10, 1'b0};
      tv[14] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd4, 16'h0555, 8'h10, 1'b0};
      tv[15] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd4, 16'h0555, 8'h00, 1'b1};

      for (int i = 0; i < 8; i++) rf[i] = '0;
      idle_inputs();
      #1 reset = 1'b1;
      #2;
      chk("reset a_ready", 32'(bus.a_ready), 32'd1);
      chk("reset b_ready", 32'(bus.b_ready), 32'd1);
      chk("reset we", 32'(bus.we), 32'd0);
      chk("reset ws", 32'(bus.ws), 32'd0);
      chk("reset wd", 32'(bus.wd), 32'd0);
      chk("reset pend_mask", 32'(bus.pend_mask), 32'h00);
      chk("reset idle", 32'(bus.idle), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bus.a_valid = tv[i].av; bus.a_addr = tv[i].aa; bus.a_data = tv[i].ad;
         bus.b_valid = tv[i].bv; bus.b_addr = tv[i].ba; bus.b_data = tv[i].bd;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d a_ready", i), 32'(bus.a_ready), 32'(tv[i].ar));
         chk($sformatf("vec%0d b_ready", i), 32'(bus.b_ready), 32'(tv[i].br));
         chk($sformatf("vec%0d we", i), 32'(bus.we), 32'(tv[i].we));
         chk($sformatf("vec%0d ws", i), 32'(bus.ws), 32'(tv[i].ws));
         chk($sformatf("vec%0d wd", i), 32'(bus.wd), 32'(tv[i].wd));
         chk($sformatf("vec%0d pend_mask", i), 32'(bus.pend_mask), 32'(tv[i].pm));
         chk($sformatf("vec%0d idle", i), 32'(bus.idle), 32'(tv[i].idle));
      end
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rf R5", 32'(rf[5]), 32'h1234);
      chk("rf R2 last of tie", 32'(rf[2]), 32'h0002);
      chk("rf R1 later wins", 32'(rf[1]), 32'hAAAA);
      chk("rf R3", 32'(rf[3]), 32'h0333);
      chk("rf R4 later wins", 32'(rf[4]), 32'h0555);

      // Reset while A holds an R3 write that has not reached the port yet.
      r3_before = r3_writes;
      @(negedge clk);
      bus.a_valid = 1'b1; bus.a_addr = 3'd3; bus.a_data = 16'h3333;
      @(posedge clk);
      #1;
      chk("pre-reset pend_mask", 32'(bus.pend_mask), 32'h08);
      idle_inputs();
      #1 reset = 1'b1;
      #1;
      chk("mid reset we", 32'(bus.we), 32'd0);
      chk("mid reset pend_mask", 32'(bus.pend_mask), 32'h00);
      chk("mid reset idle", 32'(bus.idle), 32'd1);
      chk("mid reset a_ready", 32'(bus.a_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("discarded R3 write", r3_writes, r3_before);

      // Saturation: both stream for 20 cycles.
      start = wlog.size();
      stream(20, 20, 20, nacc);
      chk("sat accepts", nacc, 21);
      drain_check("sat", start, 21, 1'b1);

      // Back-pressure: both loaded together, B then stops, A keeps streaming.
      start = wlog.size();
      stream(12, 12, 1, nacc);
      chk("bp accepts", nacc, 12);
      chk("bp b_ready full", 32'(brdy[1]), 32'd0);
      chk("bp b_ready draining", 32'(brdy[2]), 32'd1);
      chk("bp a_ready blocked", 32'(ardy[2]), 32'd0);
      chk("bp a_ready resumed", 32'(ardy[3]), 32'd1);
      drain_check("bp", start, 12, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
